// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: major opcodes, loader field-bundle classes and
// the loader FSM state encoding.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Encodings 5-7 are not used and mark a bundle as illegal.
    typedef enum logic [2:0] {
        CLS_LW     = 3'd0,
        CLS_SW     = 3'd1,
        CLS_R      = 3'd2,
        CLS_I      = 3'd3,
        CLS_BRANCH = 3'd4
    } instr_class_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } ldr_state_t;

endpackage

// File: rtl/rv32_field_encoder.sv
// Combinational RV32I encoder: builds a machine word from a decoded field
// bundle and flags bundles that cannot be encoded.
module rv32_field_encoder
    import riscv_pkg::*;
(
    input  logic [2:0]  i_class,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_funct3,
    input  logic        i_funct7_5,
    input  logic [12:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_illegal
);

    // 12-bit immediates must be a sign extension of bit 11 into bit 12.
    logic w_imm12_ovf;
    assign w_imm12_ovf = i_imm[12] ^ i_imm[11];

    // Field packing per class; LW/SW always use funct3 = word (3'b010).
    always_comb begin
        o_word    = 32'h0;
        o_illegal = 1'b0;
        case (i_class)
            CLS_LW: begin
                o_word    = {i_imm[11:0], i_rs1, 3'b010, i_rd, OP_LOAD};
                o_illegal = w_imm12_ovf;
            end
            CLS_SW: begin
                o_word    = {i_imm[11:5], i_rs2, i_rs1, 3'b010, i_imm[4:0], OP_STORE};
                o_illegal = w_imm12_ovf;
            end
            CLS_R: begin
                o_word = {1'b0, i_funct7_5, 5'b0, i_rs2, i_rs1, i_funct3, i_rd, OP_RTYPE};
            end
            CLS_I: begin
                o_word    = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_ITYPE};
                o_illegal = w_imm12_ovf;
            end
            CLS_BRANCH: begin
                o_word    = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                             i_imm[4:1], i_imm[11], OP_BRANCH};
                // Branch offsets are halfword aligned.
                o_illegal = i_imm[0];
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Streaming instruction encoder / imem preloader. Accepts field bundles in
// LOAD, writes each encoded word to the next sequential imem address one
// cycle later, and stops accepting once the memory is full.
module instr_encoder_loader
    import riscv_pkg::*;
#(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  finish,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_class,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [2:0]            in_funct3,
    input  logic                  in_funct7_5,
    input  logic [12:0]           in_imm,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  busy,
    output logic                  done,
    output logic                  full,
    output logic                  err_illegal
);

    localparam int unsigned CAP = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CAP_W = CAP[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] ONE_W = {{ADDR_WIDTH{1'b0}}, 1'b1};

    ldr_state_t             r_state, w_state_nxt;
    logic [ADDR_WIDTH:0]    r_count;
    logic                   r_we;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [31:0]            r_wdata;
    logic                   r_err;

    logic [31:0]            w_word;
    logic                   w_illegal;
    logic                   w_full;
    logic                   w_ready;
    logic                   w_xfer;
    logic                   w_write;

    rv32_field_encoder u_enc (
        .i_class    (in_class),
        .i_rd       (in_rd),
        .i_rs1      (in_rs1),
        .i_rs2      (in_rs2),
        .i_funct3   (in_funct3),
        .i_funct7_5 (in_funct7_5),
        .i_imm      (in_imm),
        .o_word     (w_word),
        .o_illegal  (w_illegal)
    );

    // start outranks any transfer, so it also masks ready.
    assign w_full  = (r_count == CAP_W);
    assign w_ready = (r_state == ST_LOAD) && !w_full && !finish && !start;
    assign w_xfer  = in_valid && w_ready;
    assign w_write = w_xfer && !w_illegal;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state: start restarts a session from anywhere, finish ends LOAD.
    always_comb begin
        w_state_nxt = r_state;
        if (start)
            w_state_nxt = ST_LOAD;
        else if (finish && r_state == ST_LOAD)
            w_state_nxt = ST_DONE;
    end

    // Word counter, sticky error flag and the one-cycle write register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            r_we <= w_write;
            if (w_write) begin
                r_addr  <= r_count[ADDR_WIDTH-1:0];
                r_wdata <= w_word;
            end
            if (start)
                r_count <= '0;
            else if (w_write)
                r_count <= r_count + ONE_W;
            if (start)
                r_err <= 1'b0;
            else if (w_xfer && w_illegal)
                r_err <= 1'b1;
        end
    end

    assign in_ready    = w_ready;
    assign imem_we     = r_we;
    assign imem_addr   = r_addr;
    assign imem_wdata  = r_wdata;
    assign word_count  = r_count;
    assign busy        = (r_state == ST_LOAD);
    assign done        = (r_state == ST_DONE);
    assign full        = w_full;
    assign err_illegal = r_err;

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Streaming RV32I instruction encoder and instruction-memory loader. It is the inverse of the main control decoder's opcode classes. It accepts decoded instruction fields over a valid/ready handshake, builds the 32-bit machine word for the five supported classes (load word, store word, R-type, I-type ALU, branch), and writes the words into sequential instruction-memory locations. It sits between the test/boot host and the instruction memory, and is used to preload programs before the core runs.

Parameters:
- ADDR_WIDTH, 6, word-address width of the instruction memory; capacity is 2^ADDR_WIDTH words.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; clears word count and error flag, enters LOAD
- finish  in  1  one-cycle pulse; ends the load session, enters DONE
- in_valid  in  1  field bundle valid
- in_ready  out  1  block can accept a bundle this cycle
- in_class  in  3  0=LW, 1=SW, 2=R, 3=I, 4=BRANCH; 5-7 illegal
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_funct3  in  3  funct3 field
- in_funct7_5  in  1  bit 30 of the instruction; R-type only (sub/sra)
- in_imm  in  13  signed immediate; bit 12 is the sign bit
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_WIDTH  word address
- imem_wdata  out  32  encoded instruction word
- word_count  out  ADDR_WIDTH+1  number of words written this session
- busy  out  1  high in LOAD
- done  out  1  high in DONE
- full  out  1  word_count == 2^ADDR_WIDTH
- err_illegal  out  1  sticky; set by any rejected bundle

Behaviour:
- Reset: FSM=IDLE. imem_we, busy, done, full and err_illegal are 0. imem_addr, imem_wdata and word_count are 0.
- FSM states: IDLE, LOAD, DONE.
  - IDLE -> LOAD on start.
  - LOAD -> DONE on finish.
  - DONE -> LOAD on start.
  - start in any state clears word_count and err_illegal, and makes the next write go to address 0.
- in_ready = (state==LOAD) && !full && !finish.
- A transfer occurs when in_valid && in_ready. There is no internal queue.
- Latency: 1 cycle. For a bundle accepted in cycle N:
  - imem_we is high in cycle N+1, with imem_addr = word_count(N)[ADDR_WIDTH-1:0] and imem_wdata set to the encoded word.
  - word_count increments at the end of cycle N.
- imem_we is a single-cycle strobe. Back-to-back transfers give a write every cycle.
- Encoding, by class:
  - LW: {imm[11:0], rs1, 3'b010, rd, 7'b0000011}. funct3 input is ignored.
  - SW: {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011}.
  - R: {1'b0, funct7_5, 5'b0, rs2, rs1, funct3, rd, 7'b0110011}.
  - I: {imm[11:0], rs1, funct3, rd, 7'b0010011}.
  - BRANCH: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011}.
- A bundle is illegal, and is consumed (in_ready honoured) without a write, if any of these hold:
  - class is 5-7;
  - class is LW, SW or I and imm[12] != imm[11] (value out of 12-bit range);
  - class is BRANCH and imm[0] == 1.
- An illegal bundle sets err_illegal, and err_illegal holds until start or rst.
- Full: when word_count reaches 2^ADDR_WIDTH, in_ready drops. No wrap-around ever occurs. The FSM stays in LOAD until finish.
- Simultaneous events:
  - start in the same cycle as a transfer: start wins, the bundle is not accepted, and in_ready is forced low that cycle.
  - finish in the same cycle as in_valid: no transfer.
- A write already in flight (cycle N+1) completes even if start or finish arrives in cycle N+1.
- rst mid-session: the pending imem_we is suppressed (0 in the next cycle) and all state returns to reset values.

Decomposition:
- Shared package (riscv_pkg) holds:
  - opcode constants OP_LOAD=7'b0000011, OP_STORE=7'b0100011, OP_RTYPE=7'b0110011, OP_ITYPE=7'b0010011, OP_BRANCH=7'b1100011, shared with the control decoder;
  - the in_class enum values;
  - the FSM state encoding.
- One combinational sub-module, rv32_field_encoder. It takes the class and fields and outputs the 32-bit word plus an illegal flag. The top level holds the FSM, counter and output register.

Test Plan:
- rst, start; send R add (rd=3, rs1=1, rs2=2, f3=0, f7_5=0) -> next cycle imem_we=1, addr=0, wdata=0x002081B3; word_count=1.
- Back-to-back transfers LW (rd=5, rs1=2, imm=8), SW (rs2=5, rs1=2, imm=12), I (rd=1, rs1=0, f3=0, imm=-1) -> wdata 0x00812283 at addr 0, 0x00512623 at addr 1, 0xFFF00093 at addr 2, on consecutive cycles.
- BRANCH (rs1=1, rs2=2, f3=0, imm=-4) -> 0xFE208EE3. Then the same bundle with imm=3 -> no write, err_illegal=1; a following start clears err_illegal and word_count.
- Class 6, then I with imm=13'h0800 -> both rejected, no imem_we, err_illegal=1, word_count unchanged.
- ADDR_WIDTH=2: send 5 valid bundles -> 4 writes at addr 0-3, full=1, in_ready=0, 5th bundle held; then finish -> done=1.
- Assert rst in the cycle after an acceptance -> imem_we=0, all outputs at reset values; start at the same time as in_valid -> no transfer that cycle.
